// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader: the default program
// terminator and the loader state encoding.
package instruction_loader_pkg;

    // Word that ends a program; it is still written to memory.
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    // Loader states. The encoding is fixed so that debug tooling can decode it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

endpackage

// File: rtl/loader_word_assembler.sv
// Groups the incoming program bytes into 32-bit big-endian words.
// A 2-bit phase counts bytes within the current word. The three previous
// bytes of the word are kept in a history register.
// The word output combines that history with the byte being accepted, so the
// parent sees the complete word in the same cycle it accepts the last byte.
module loader_word_assembler (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_complete,
    output logic [31:0] o_word
);

    logic [1:0]  phase_q;
    logic [1:0]  phase_d;
    // Lower three bytes of the conceptual 32-bit shift register. The top
    // byte would be shifted out on the next byte, so it is never needed.
    logic [23:0] hist_q;
    logic [23:0] hist_d;

    // Next phase/history: clear on a new load, otherwise shift in each accepted byte.
    always_comb begin
        phase_d = phase_q;
        hist_d  = hist_q;
        if (i_clear) begin
            phase_d = 2'd0;
            hist_d  = 24'd0;
        end else if (i_byte_valid) begin
            phase_d = phase_q + 2'd1;
            hist_d  = {hist_q[15:0], i_byte};
        end
    end

    // Phase and history registers, cleared asynchronously.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            phase_q <= 2'd0;
            hist_q  <= 24'd0;
        end else begin
            phase_q <= phase_d;
            hist_q  <= hist_d;
        end
    end

    assign o_word_complete = i_byte_valid && (phase_q == 2'd3);
    assign o_word          = {hist_q, i_byte};

endmodule

// File: rtl/instruction_loader.sv
// Feeds the byte-wide instruction memory from the debug UART byte stream.
// Bytes are written at consecutive addresses from 0, one cycle after arrival.
// A load ends in DONE when the HALT word is seen. It ends in ERROR when the
// last memory cell is written without completing a HALT word.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int unsigned NBITS     = 8,
    parameter int unsigned CELLS     = 256,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic [NBITS-1:0] o_mem_addr,
    output logic [7:0]       o_mem_data,
    output logic             o_mem_wr_en,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [NBITS-1:0] o_inst_count
);

    localparam logic [NBITS-1:0] LAST_ADDR = NBITS'(CELLS - 1);
    localparam logic [NBITS-1:0] ADDR_ONE  = NBITS'(1);

    state_t           state_q;
    state_t           state_d;
    logic [NBITS-1:0] ptr_q;
    logic [NBITS-1:0] ptr_d;
    logic [NBITS-1:0] addr_q;
    logic [NBITS-1:0] addr_d;
    logic [7:0]       data_q;
    logic [7:0]       data_d;
    logic             wr_en_q;
    logic             wr_en_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;
    logic             error_q;
    logic             error_d;
    logic [NBITS-1:0] count_q;
    logic [NBITS-1:0] count_d;

    logic             rx_accept;
    logic             start_load;
    logic             word_complete;
    logic [31:0]      word;
    logic             halt_seen;

    // Bytes only count while loading. A start request outside LOAD always
    // wins, so a byte arriving with it in IDLE is dropped.
    assign rx_accept  = (state_q == ST_LOAD) && i_rx_valid;
    assign start_load = (state_q != ST_LOAD) && i_start;
    assign halt_seen  = word_complete && (word == HALT_WORD);

    loader_word_assembler u_word_assembler (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_clear         (start_load),
        .i_byte_valid    (rx_accept),
        .i_byte          (i_rx_data),
        .o_word_complete (word_complete),
        .o_word          (word)
    );

    // Next-state and next-output logic for the load FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_en_d = 1'b0;
        done_d  = done_q;
        error_d = error_q;
        count_d = count_q;

        case (state_q)
            ST_LOAD: begin
                if (rx_accept) begin
                    wr_en_d = 1'b1;
                    addr_d  = ptr_q;
                    data_d  = i_rx_data;
                    ptr_d   = ptr_q + ADDR_ONE;
                    if (word_complete) begin
                        count_d = count_q + ADDR_ONE;
                    end
                    if (halt_seen) begin
                        // HALT wins even when it fills the last cell.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (ptr_q == LAST_ADDR) begin
                        // Memory is full without a HALT: stop, never wrap.
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            default: begin
                // IDLE, DONE and ERROR all restart a load on i_start.
                if (i_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end
            end
        endcase

        busy_d = (state_d == ST_LOAD);
    end

    // FSM state and all registered outputs. Reset drops any pending write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            data_q  <= 8'd0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            count_q <= count_d;
        end
    end

    assign o_mem_addr   = addr_q;
    assign o_mem_data   = data_q;
    assign o_mem_wr_en  = wr_en_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_error      = error_q;
    assign o_inst_count = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: drives bytes on the falling edge,
// logs every write pulse seen on the falling edge, and checks the log
// against hand-computed addresses, data, flags and timing.
module tb_instruction_loader;

    localparam int LOG = 1024;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic [7:0] o_mem_addr;
    logic [7:0] o_mem_data;
    logic       o_mem_wr_en;
    logic       o_busy;
    logic       o_done;
    logic       o_error;
    logic [7:0] o_inst_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Write log filled by the monitor.
    int         n_wr = 0;
    logic [7:0] wr_addr [0:LOG-1];
    logic [7:0] wr_data [0:LOG-1];
    logic       wr_done [0:LOG-1];
    logic       wr_err  [0:LOG-1];
    int         wr_cyc  [0:LOG-1];

    // Cycle at which each byte was presented.
    int drv_n = 0;
    int drv_cyc [0:LOG-1];

    instruction_loader #(
        .NBITS     (8),
        .CELLS     (256),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data),
        .o_mem_wr_en  (o_mem_wr_en),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_inst_count (o_inst_count)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_mem_wr_en && n_wr < LOG) begin
            wr_addr[n_wr] <= o_mem_addr;
            wr_data[n_wr] <= o_mem_data;
            wr_done[n_wr] <= o_done;
            wr_err[n_wr]  <= o_error;
            wr_cyc[n_wr]  <= cyc;
            n_wr          <= n_wr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge i_clk);
        i_start    = 1'b0;
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        drv_cyc[drv_n] = cyc;
        drv_n++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge i_clk);
            i_start    = 1'b0;
            i_rx_valid = 1'b0;
        end
    endtask

    task automatic do_start();
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        i_start    = 1'b1;
        @(negedge i_clk);
        i_start    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int db;
        logic [7:0] t2 [0:7];
        logic [7:0] t6 [0:3];
        t2 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        t6 = '{8'hAB, 8'hCD, 8'hEF, 8'h01};

        i_rst = 1'b1; i_start = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00;
        idle(3);
        check("rst wr_en", {31'd0, o_mem_wr_en}, 32'd0);
        check("rst busy", {31'd0, o_busy}, 32'd0);
        check("rst done", {31'd0, o_done}, 32'd0);
        check("rst error", {31'd0, o_error}, 32'd0);
        check("rst count", {24'd0, o_inst_count}, 32'd0);
        check("rst addr", {24'd0, o_mem_addr}, 32'd0);
        i_rst = 1'b0;
        idle(2);

        // 1: reset mid-stream aborts, then bytes without start are dropped
        base = n_wr;
        do_start();
        check("t1 busy", {31'd0, o_busy}, 32'd1);
        put(8'h55);
        put(8'h66);
        #2 i_rst = 1'b1;
        #1;
        check("t1 async wr_en", {31'd0, o_mem_wr_en}, 32'd0);
        check("t1 async busy", {31'd0, o_busy}, 32'd0);
        check("t1 async data", {24'd0, o_mem_data}, 32'd0);
        idle(1);
        i_rst = 1'b0;
        put(8'h77);
        idle(3);
        check("t1 writes", n_wr - base, 1);
        check("t1 addr0", {24'd0, wr_addr[base]}, 32'd0);
        check("t1 data0", {24'd0, wr_data[base]}, 32'h55);
        check("t1 busy after", {31'd0, o_busy}, 32'd0);
        check("t1 count", {24'd0, o_inst_count}, 32'd0);

        // 2: short program ending in HALT
        base = n_wr;
        do_start();
        for (int i = 0; i < 8; i++) put(t2[i]);
        idle(3);
        check("t2 writes", n_wr - base, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2 addr[%0d]", i), {24'd0, wr_addr[base+i]}, i);
            check($sformatf("t2 data[%0d]", i), {24'd0, wr_data[base+i]}, {24'd0, t2[i]});
        end
        check("t2 done@6", {31'd0, wr_done[base+6]}, 32'd0);
        check("t2 done@7", {31'd0, wr_done[base+7]}, 32'd1);
        check("t2 done", {31'd0, o_done}, 32'd1);
        check("t2 busy", {31'd0, o_busy}, 32'd0);
        check("t2 count", {24'd0, o_inst_count}, 32'd2);

        // 3: overflow without HALT
        base = n_wr;
        do_start();
        check("t3 done drop", {31'd0, o_done}, 32'd0);
        for (int i = 0; i < 256; i++) put(8'h11);
        idle(2);
        check("t3 writes", n_wr - base, 256);
        for (int i = 0; i < 256; i++) begin
            check($sformatf("t3 addr[%0d]", i), {24'd0, wr_addr[base+i]}, i);
        end
        check("t3 data last", {24'd0, wr_data[base+255]}, 32'h11);
        check("t3 err@254", {31'd0, wr_err[base+254]}, 32'd0);
        check("t3 err@255", {31'd0, wr_err[base+255]}, 32'd1);
        put(8'h11);
        idle(3);
        check("t3 no 257th", n_wr - base, 256);
        check("t3 error", {31'd0, o_error}, 32'd1);
        check("t3 busy", {31'd0, o_busy}, 32'd0);
        check("t3 count", {24'd0, o_inst_count}, 32'd64);

        // 4: HALT exactly filling the memory
        base = n_wr;
        do_start();
        check("t4 error drop", {31'd0, o_error}, 32'd0);
        for (int i = 0; i < 252; i++) put(8'h11);
        for (int i = 0; i < 4; i++) put(8'hFF);
        idle(3);
        check("t4 writes", n_wr - base, 256);
        check("t4 addr last", {24'd0, wr_addr[base+255]}, 32'd255);
        check("t4 data last", {24'd0, wr_data[base+255]}, 32'hFF);
        check("t4 done@255", {31'd0, wr_done[base+255]}, 32'd1);
        check("t4 err@255", {31'd0, wr_err[base+255]}, 32'd0);
        check("t4 done", {31'd0, o_done}, 32'd1);
        check("t4 error", {31'd0, o_error}, 32'd0);
        check("t4 count", {24'd0, o_inst_count}, 32'd64);

        // 5: start inside LOAD is ignored, start after DONE restarts
        base = n_wr;
        do_start();
        put(8'hA0);
        put(8'hA1);
        idle(1);
        do_start();
        put(8'hA2);
        put(8'hA3);
        for (int i = 0; i < 4; i++) put(8'hFF);
        idle(3);
        check("t5 writes", n_wr - base, 8);
        check("t5 addr[2]", {24'd0, wr_addr[base+2]}, 32'd2);
        check("t5 data[2]", {24'd0, wr_data[base+2]}, 32'hA2);
        check("t5 addr[7]", {24'd0, wr_addr[base+7]}, 32'd7);
        check("t5 done", {31'd0, o_done}, 32'd1);
        check("t5 count", {24'd0, o_inst_count}, 32'd2);
        base = n_wr;
        do_start();
        check("t5 restart done", {31'd0, o_done}, 32'd0);
        check("t5 restart busy", {31'd0, o_busy}, 32'd1);
        check("t5 restart count", {24'd0, o_inst_count}, 32'd0);
        put(8'h5A);
        idle(2);
        check("t5 restart writes", n_wr - base, 1);
        check("t5 restart addr", {24'd0, wr_addr[base]}, 32'd0);
        check("t5 restart data", {24'd0, wr_data[base]}, 32'h5A);

        // 6: start+byte in IDLE drops the byte; back-to-back bytes
        i_rst = 1'b1;
        idle(1);
        i_rst = 1'b0;
        idle(1);
        base = n_wr;
        @(negedge i_clk);
        i_start    = 1'b1;
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h99;
        db = drv_n;
        for (int i = 0; i < 4; i++) put(t6[i]);
        idle(3);
        check("t6 writes", n_wr - base, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6 addr[%0d]", i), {24'd0, wr_addr[base+i]}, i);
            check($sformatf("t6 data[%0d]", i), {24'd0, wr_data[base+i]}, {24'd0, t6[i]});
            check($sformatf("t6 lat[%0d]", i), wr_cyc[base+i], drv_cyc[db+i] + 1);
        end
        check("t6 count", {24'd0, o_inst_count}, 32'd1);
        check("t6 done", {31'd0, o_done}, 32'd0);
        check("t6 busy", {31'd0, o_busy}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
